// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant and owner index.
// Build option RR_ARB_TIMEOUT_EN adds a hold counter that forces handover after HOLD_MAX cycles.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:3] req,
  output logic [0:3] gnt,
  output logic [0:1] sel,
  output logic       busy,
  output logic       dbg_state_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] sel_q;
  logic [0:3] gnt_q;
  logic       busy_q;

  logic [1:0] idle_win_d;
  logic [1:0] hand_start_d;
  logic [1:0] hand_win_d;
  logic       release_d;
  logic       timeout_d;

  if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold_max
    $error("rr_arbiter4: HOLD_MAX must be in 2..15");
  end

  // First set bit of r, scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] pick(input logic [0:3] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Bit 0 is the leftmost grant bit, so index 0 decodes to 1000.
  function automatic logic [0:3] decode(input logic [1:0] s);
    decode    = 4'b0000;
    decode[s] = 1'b1;
  endfunction

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  logic [3:0] hold_q;
  logic       others_d;

  always_comb begin
    others_d  = |(req & ~decode(sel_q));
    timeout_d = (hold_q == HOLD_LAST) && others_d;
  end
`else
  always_comb begin
    timeout_d = 1'b0;
  end
`endif

  always_comb begin
    idle_win_d   = pick(req, ptr_q);
    hand_start_d = sel_q + 2'd1;
    hand_win_d   = pick(req, hand_start_d);
    release_d    = !req[sel_q] || timeout_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q  <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            sel_q   <= idle_win_d;
            gnt_q   <= decode(idle_win_d);
            busy_q  <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q  <= 4'd0;
`endif
          end
        end
        GRANT: begin
          if (release_d) begin
            // Pointer moves past the outgoing owner, so it ranks last next time.
            ptr_q <= hand_start_d;
            if (|req) begin
              sel_q  <= hand_win_d;
              gnt_q  <= decode(hand_win_d);
`ifdef RR_ARB_TIMEOUT_EN
              hold_q <= 4'd0;
`endif
            end else begin
              state_q <= IDLE;
              gnt_q   <= 4'b0000;
              busy_q  <= 1'b0;
            end
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            if (hold_q != HOLD_LAST) begin
              hold_q <= hold_q + 4'd1;
            end
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign sel         = sel_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, handover order, wrap, back-to-back rotation,
// mid-grant reset and the hold-timeout behaviour (or its absence in the default build).
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [0:3] req;
  logic [0:3] gnt;
  logic [0:1] sel;
  logic       busy;
  logic       dbg_state;

  int n_assert;
  int n_fail;

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .sel        (sel),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [0:3] exp_gnt,
                     input logic [1:0] exp_sel, input logic exp_busy);
    n_assert++;
    assert (gnt === exp_gnt) else begin
      n_fail++;
      $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, exp_gnt);
    end
    n_assert++;
    assert (sel === exp_sel) else begin
      n_fail++;
      $error("FAIL %s sel observed=%0d expected=%0d", tag, sel, exp_sel);
    end
    n_assert++;
    assert (busy === exp_busy) else begin
      n_fail++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, exp_busy);
    end
    n_assert++;
    assert ($onehot0(gnt)) else begin
      n_fail++;
      $error("FAIL %s onehot observed=%b expected=one-hot-or-zero", tag, gnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [0:3] r;
    logic [0:3] eg;
    logic [1:0] es;
    logic [1:0] cur;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    chk("reset", 4'b0000, 2'd0, 1'b0);

    // Idle with no requests for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_no_req", 4'b0000, 2'd0, 1'b0);
    end

    // Two requesters, released one after the other.
    req = 4'b0110;
    tick();
    chk("first_grant", 4'b0100, 2'd1, 1'b1);
    tick();
    chk("hold_1", 4'b0100, 2'd1, 1'b1);
    req = 4'b0010;
    tick();
    chk("handover_2", 4'b0010, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    chk("to_idle", 4'b0000, 2'd2, 1'b0);
    tick();
    chk("idle_keeps_sel", 4'b0000, 2'd2, 1'b0);

    // Pointer is now 3: owner 3, then wrap to 0 while 0 waits.
    req = 4'b0001;
    tick();
    chk("grant_3", 4'b0001, 2'd3, 1'b1);
    req = 4'b1001;
    tick();
    chk("nonowner_ignored", 4'b0001, 2'd3, 1'b1);
    req = 4'b1000;
    tick();
    chk("wrap_to_0", 4'b1000, 2'd0, 1'b1);

    // All four requesting; each owner releases after two cycles.
    do_reset();
    req = 4'b1111;
    tick();
    chk("rot_start", 4'b1000, 2'd0, 1'b1);
    cur = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rot_hold", 4'b1000 >> cur, cur, 1'b1);
      r      = 4'b1111;
      r[cur] = 1'b0;
      req    = r;
      cur    = cur + 2'd1;
      tick();
      chk("rot_next", 4'b1000 >> cur, cur, 1'b1);
      req = 4'b1111;
    end

    // Reset while requester 2 owns the grant.
    do_reset();
    req = 4'b1111;
    tick();
    chk("pre_rst_0", 4'b1000, 2'd0, 1'b1);
    req = 4'b0111;
    tick();
    chk("pre_rst_1", 4'b0100, 2'd1, 1'b1);
    req = 4'b1011;
    tick();
    chk("pre_rst_2", 4'b0010, 2'd2, 1'b1);
    req = 4'b1111;
    rst = 1'b1;
    tick();
    chk("mid_grant_rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_grant", 4'b1000, 2'd0, 1'b1);

    // Two requesters held constantly.
    do_reset();
    req = 4'b1100;
    for (int i = 0; i < 12; i++) begin
      tick();
`ifdef RR_ARB_TIMEOUT_EN
      es = ((i / 4) % 2 == 0) ? 2'd0 : 2'd1;
`else
      es = 2'd0;
`endif
      eg = 4'b1000 >> es;
      chk("hold_pair", eg, es, 1'b1);
    end

    // Lone owner keeps the grant regardless of timeout.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lone_owner", 4'b0010, 2'd2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
